// File: rtl/cevero_dvfs_pkg.sv
// Shared types and helpers for the DVFS governor: FSM states, window decisions
// and the default-level clamp.
package cevero_dvfs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MONITOR,
        SETTLE
    } gov_state_e;

    typedef enum logic [1:0] {
        HOLD,
        RAISE,
        LOWER,
        ALARM
    } gov_decision_e;

    function automatic int unsigned clamp_level(input int unsigned level,
                                                input int unsigned num_levels);
        return (level >= num_levels) ? num_levels - 1 : level;
    endfunction

endpackage

// File: rtl/cevero_err_window.sv
// Observation window: cycle counter, saturating popcount accumulator of the
// error inputs and a strobe for the last cycle of each window.
module cevero_err_window #(
    parameter int unsigned NumSources = 2,
    parameter int unsigned TimeFrame  = 10,
    parameter int unsigned CntW       = $clog2(TimeFrame * NumSources + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [NumSources-1:0] error_i,
    output logic [CntW-1:0]       err_count_o,
    output logic [CntW-1:0]       total_o,
    output logic                  win_end_o
);

    localparam int unsigned     WinW    = $clog2(TimeFrame);
    localparam logic [WinW-1:0] WinLast = WinW'(TimeFrame - 1);
    localparam logic [CntW-1:0] CntMax  = '1;

    logic [WinW-1:0] win_q, win_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW:0]   sum_wide;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        sum_wide = {1'b0, cnt_q};
        for (int i = 0; i < NumSources; i++) begin
            sum_wide = sum_wide + {{CntW{1'b0}}, error_i[i]};
        end
        // total_o includes this cycle's errors; it is what the window-end decision sees
        total_o   = (sum_wide > {1'b0, CntMax}) ? CntMax : sum_wide[CntW-1:0];
        win_end_o = !clear_i && (win_q == WinLast);
        win_d     = win_q + 1'b1;
        cnt_d     = total_o;
        if (clear_i || win_end_o) begin
            win_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            win_q <= '0;
            cnt_q <= '0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_count_o = cnt_q;

endmodule

// File: rtl/cevero_dvfs_governor.sv
// DVFS governor: steps the regulator level up on excessive windowed error rate
// and down after sustained clean windows, holding a settle period after changes.
module cevero_dvfs_governor
    import cevero_dvfs_pkg::*;
#(
    parameter int unsigned NumSources   = 2,
    parameter int unsigned NumLevels    = 4,
    parameter int unsigned TimeFrame    = 10,
    parameter int unsigned MaxErrorRate = 3,
    parameter int unsigned OkThreshold  = 3,
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned LevelW       = $clog2(NumLevels),
    parameter int unsigned CntW         = $clog2(TimeFrame * NumSources + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [NumSources-1:0] error_i,
    input  logic [LevelW-1:0]     def_level_i,
    output logic [LevelW-1:0]     set_level_o,
    output logic                  changing_o,
    output logic [CntW-1:0]       err_count_o,
    output logic                  alarm_o
);

    localparam int unsigned       CleanW   = $clog2(OkThreshold + 1);
    localparam int unsigned       SettleW  = $clog2(SettleCycles + 1);
    localparam logic [LevelW-1:0] LevelTop = LevelW'(NumLevels - 1);

    gov_state_e          state_q, state_d;
    gov_decision_e       decision;
    logic [LevelW-1:0]   level_q, level_d;
    logic [CleanW-1:0]   clean_q, clean_d;
    logic [SettleW-1:0]  settle_q, settle_d;
    logic                alarm_q, alarm_d;
    logic                changing_q, changing_d;
    logic                win_clear, win_end;
    logic [CntW-1:0]     win_total;

    // The window only runs in MONITOR; leaving it or dropping enable discards the partial window
    assign win_clear = (state_q != MONITOR) || !enable_i;

    cevero_err_window #(
        .NumSources (NumSources),
        .TimeFrame  (TimeFrame),
        .CntW       (CntW)
    ) u_err_window (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (win_clear),
        .error_i     (error_i),
        .err_count_o (err_count_o),
        .total_o     (win_total),
        .win_end_o   (win_end)
    );

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        clean_d  = clean_q;
        settle_d = settle_q;
        alarm_d  = alarm_q;
        decision = HOLD;

        if (win_end) begin
            if (win_total > CntW'(MaxErrorRate)) begin
                decision = (level_q == LevelTop) ? ALARM : RAISE;
            end else if (win_total == '0 && clean_q == CleanW'(OkThreshold - 1) && level_q != '0) begin
                decision = LOWER;
            end
        end

        case (state_q)
            IDLE: begin
                level_d  = LevelW'(clamp_level(32'(def_level_i), NumLevels));
                clean_d  = '0;
                settle_d = '0;
                if (enable_i) state_d = MONITOR;
            end
            MONITOR: begin
                if (win_end) begin
                    if (win_total == '0) begin
                        clean_d = (clean_q == CleanW'(OkThreshold - 1)) ? '0 : clean_q + 1'b1;
                    end else begin
                        clean_d = '0;
                    end
                    case (decision)
                        RAISE: begin
                            level_d = level_q + 1'b1;
                            state_d = SETTLE;
                        end
                        LOWER: begin
                            level_d = level_q - 1'b1;
                            state_d = SETTLE;
                        end
                        ALARM:   alarm_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            SETTLE: begin
                if (settle_q == SettleW'(SettleCycles - 1)) begin
                    settle_d = '0;
                    state_d  = MONITOR;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable overrides everything except the sticky alarm
        if (!enable_i) begin
            state_d  = IDLE;
            clean_d  = '0;
            settle_d = '0;
        end

        changing_d = (state_d == SETTLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            level_q    <= '0;
            clean_q    <= '0;
            settle_q   <= '0;
            alarm_q    <= 1'b0;
            changing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            clean_q    <= clean_d;
            settle_q   <= settle_d;
            alarm_q    <= alarm_d;
            changing_q <= changing_d;
        end
    end

    assign set_level_o = level_q;
    assign changing_o  = changing_q;
    assign alarm_o     = alarm_q;

endmodule

// File: tb/tb_cevero_dvfs_governor.sv
// Directed self-checking bench for cevero_dvfs_governor with default parameters
// (2 sources, 4 levels, 10-cycle windows, raise above 3, lower after 3 clean, settle 4).
module tb_cevero_dvfs_governor;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic [1:0] error_i;
    logic [1:0] def_level_i;
    logic [1:0] set_level_o;
    logic       changing_o;
    logic [4:0] err_count_o;
    logic       alarm_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    cevero_dvfs_governor #(
        .NumSources   (2),
        .NumLevels    (4),
        .TimeFrame    (10),
        .MaxErrorRate (3),
        .OkThreshold  (3),
        .SettleCycles (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .error_i     (error_i),
        .def_level_i (def_level_i),
        .set_level_o (set_level_o),
        .changing_o  (changing_o),
        .err_count_o (err_count_o),
        .alarm_o     (alarm_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Park in IDLE with a new default, then enable; returns in the first window cycle
    task automatic start_run(input logic [1:0] def);
        enable_i    = 1'b0;
        error_i     = 2'b00;
        def_level_i = def;
        step(2);
        enable_i = 1'b1;
        step(1);
    endtask

    // One full window with single-source errors in the first n_err cycles
    task automatic run_window(input int n_err);
        for (int i = 0; i < 10; i++) begin
            error_i = (i < n_err) ? 2'b01 : 2'b00;
            step(1);
        end
        error_i = 2'b00;
    endtask

    initial begin
        rst_i       = 1'b1;
        enable_i    = 1'b0;
        error_i     = 2'b00;
        def_level_i = 2'd1;
        step(2);
        check("rst_level",    set_level_o, 0);
        check("rst_changing", changing_o,  0);
        check("rst_err",      err_count_o, 0);
        check("rst_alarm",    alarm_o,     0);
        rst_i = 1'b0;
        step(1);
        check("idle_def_level", set_level_o, 1);

        // Raise after 4 errors; settle E+11..E+14, next window from E+15
        enable_i = 1'b1;            // cycle E
        step(1);                    // E+1
        error_i = 2'b01;
        step(4);                    // E+5
        error_i = 2'b00;
        check("t1_err_mid", err_count_o, 4);
        step(5);                    // E+10
        check("t1_level_last_win", set_level_o, 1);
        check("t1_chg_last_win",   changing_o,  0);
        check("t1_err_last_win",   err_count_o, 4);
        step(1);                    // E+11
        check("t1_level_raised", set_level_o, 2);
        check("t1_chg_e11",      changing_o,  1);
        check("t1_err_cleared",  err_count_o, 0);
        step(3);                    // E+14
        check("t1_chg_e14", changing_o, 1);
        step(1);                    // E+15
        check("t1_chg_e15",   changing_o,  0);
        check("t1_level_e15", set_level_o, 2);
        error_i = 2'b01;
        step(1);                    // E+16
        error_i = 2'b00;
        check("t1_new_window_counts", err_count_o, 1);

        // Exactly MaxErrorRate per window holds; three clean windows lower
        start_run(2'd1);
        for (int w = 0; w < 5; w++) begin
            run_window(3);
            check("t2_level_hold3", set_level_o, 1);
            check("t2_chg_hold3",   changing_o,  0);
        end
        check("t2_err_cleared", err_count_o, 0);
        run_window(0);
        check("t2_level_clean1", set_level_o, 1);
        run_window(0);
        check("t2_level_clean2", set_level_o, 1);
        run_window(0);
        check("t2_level_lowered", set_level_o, 0);
        check("t2_chg_lowered",   changing_o,  1);

        // Raise at top level sets sticky alarm, survives enable toggle
        start_run(2'd3);
        check("t3_level_start", set_level_o, 3);
        run_window(5);
        check("t3_level_top", set_level_o, 3);
        check("t3_alarm_set", alarm_o,     1);
        check("t3_no_settle", changing_o,  0);
        enable_i = 1'b0;
        step(2);
        check("t3_alarm_idle", alarm_o, 1);
        enable_i = 1'b1;
        step(2);
        check("t3_alarm_reenable", alarm_o, 1);
        rst_i = 1'b1;
        step(1);
        check("t3_alarm_rst", alarm_o, 0);
        rst_i = 1'b0;

        // Both sources count; last-cycle errors count; settle errors ignored
        start_run(2'd1);
        step(2);                    // w2
        error_i = 2'b11;
        step(2);                    // w4
        error_i = 2'b00;
        check("t4_err_dual", err_count_o, 4);
        step(6);                    // first settle cycle
        check("t4_level_raised", set_level_o, 2);
        check("t4_chg",          changing_o,  1);
        error_i = 2'b11;
        step(4);                    // w0 of next window
        error_i = 2'b00;
        check("t4_settle_err_ignored", err_count_o, 0);
        check("t4_chg_done",           changing_o,  0);
        check("t4_level_after_settle", set_level_o, 2);
        step(8);                    // w8
        error_i = 2'b11;
        step(1);                    // w9
        check("t4_err_w9", err_count_o, 2);
        step(1);
        error_i = 2'b00;
        check("t4_last_cycle_raise", set_level_o, 3);
        check("t4_last_cycle_chg",   changing_o,  1);

        // Disable mid-window, then out-of-range default
        start_run(2'd2);
        error_i = 2'b01;
        step(3);
        error_i = 2'b00;
        check("t5_err_before_disable", err_count_o, 3);
        enable_i = 1'b0;
        step(1);
        check("t5_err_idle",   err_count_o, 0);
        check("t5_level_idle", set_level_o, 2);
        check("t5_chg_idle",   changing_o,  0);
        def_level_i = 2'(7);        // 7 truncates onto the 2-bit port, the top level
        step(1);
        check("t5_def_clamped", set_level_o, 3);

        // Reset in the middle of SETTLE
        start_run(2'd1);
        run_window(4);
        check("t6_in_settle", changing_o, 1);
        step(1);
        rst_i = 1'b1;
        step(1);
        check("t6_rst_level", set_level_o, 0);
        check("t6_rst_chg",   changing_o,  0);
        check("t6_rst_err",   err_count_o, 0);
        check("t6_rst_alarm", alarm_o,     0);
        rst_i = 1'b0;
        step(1);
        check("t6_idle_def", set_level_o, 1);
        check("t6_idle_chg", changing_o,  0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cevero_dvfs_governor.md
# cevero_dvfs_governor

Parametrised, multi-source successor to the single-error DVFS monitor in the fault-tolerant SoC. It aggregates error pulses from `NumSources` fault-tolerant cores or lockstep checkers over fixed observation windows. It steps a discrete voltage level up on excessive error rate and down after sustained clean operation, holding a settle period after every change. It sits beside the core cluster at SoC top level and drives the regulator level request.

## Interface
- `NumSources`, 2, number of independent error inputs
- `NumLevels`, 4, number of voltage levels (level 0 = lowest voltage)
- `TimeFrame`, 10, window length in cycles (≥2)
- `MaxErrorRate`, 3, window error count above which level is raised
- `OkThreshold`, 3, consecutive zero-error windows before level is lowered (≥1)
- `SettleCycles`, 4, post-change hold in cycles (≥1)
- Derived: `LevelW = $clog2(NumLevels)`; `CntW = $clog2(TimeFrame*NumSources+1)`
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous reset, active-high
- `enable_i`  in  1  governor active; low = idle, output follows default
- `error_i`  in  NumSources  per-source error pulse; each high bit counts 1 per cycle
- `def_level_i`  in  LevelW  default/start level, clamped to NumLevels-1
- `set_level_o`  out  LevelW  registered level request to regulator
- `changing_o`  out  1  high during SETTLE
- `err_count_o`  out  CntW  running error count of current window
- `alarm_o`  out  1  sticky: raise requested while already at NumLevels-1

## Operation
- Reset values:
  - `set_level_o`=0, `changing_o`=0, `err_count_o`=0, `alarm_o`=0.
  - State IDLE; window, clean and settle counters 0.
- FSM has three states: IDLE, MONITOR and SETTLE.
- IDLE:
  - `set_level_o` loads clamp(`def_level_i`) every cycle; counters held at 0.
  - `enable_i`=1 moves to MONITOR next cycle.
- MONITOR:
  - Window counter runs 0..TimeFrame-1.
  - Each cycle `err_count` += popcount(`error_i`), saturating at 2^CntW-1.
  - The last window cycle decides on the count including that cycle's errors:
    - count > MaxErrorRate:
      - level < NumLevels-1: level+1, clean=0, go to SETTLE.
      - level = NumLevels-1: level unchanged, `alarm_o`←1, clean=0, stay in MONITOR.
    - count == 0:
      - clean+1. If clean reaches OkThreshold: clean=0.
      - If level > 0: level-1 and go to SETTLE; else stay in MONITOR.
    - 1 ≤ count ≤ MaxErrorRate: clean=0, no change.
  - `err_count` and the window counter clear after every decision.
- SETTLE:
  - `changing_o`=1 and `error_i` is ignored.
  - Lasts exactly SettleCycles cycles, then MONITOR with window counter 0.
- `enable_i`=0 in any state forces IDLE next cycle and clears counters. `alarm_o` is kept.
- `alarm_o` clears only on `rst_i`.
- Reset dominates `enable_i` and all events.

## Timing
- `enable_i` rises at cycle E → MONITOR at E+1. Window cycles are E+1..E+TimeFrame.
- The decision registers at the end of the last window cycle. `set_level_o` and `changing_o` change in the following cycle.
- SETTLE spans SettleCycles cycles. The next window starts the cycle after.
- `err_count_o` is registered and reflects errors up to the previous cycle.
- Level changes by at most one step per window. It never changes in SETTLE or IDLE, except for IDLE default tracking.
- Reset asserted mid-window or mid-settle: all reset values apply the next cycle. No decision fires for the partial window.

## Structure
- Package `cevero_dvfs_pkg`:
  - `gov_state_e` (IDLE, MONITOR, SETTLE).
  - `gov_decision_e` (HOLD, RAISE, LOWER, ALARM).
  - Level clamp function.
- Sub-module `cevero_err_window`:
  - Contains the window counter, saturating popcount accumulator and window-end strobe.
  - Takes a `clear_i` input.
- Top contains the FSM, clean counter, settle counter and level register.

## Test plan
1. `def_level_i`=1, enable; 4 errors in window 1 → `set_level_o`=2 at E+11; `changing_o` high E+11..E+14; window restarts E+15.
2. `def_level_i`=1; exactly 3 errors per window for 5 windows → level stays 1; clean count stays 0; then 3 clean windows → level 0.
3. `def_level_i`=3; 5 errors → level stays 3; `alarm_o`=1 and stays set through `enable_i` toggle; clears only on `rst_i`.
4. Both sources high for 2 cycles in one window → `err_count_o`=4 → raise. Errors only in the last window cycle are counted. Errors during SETTLE have no effect.
5. `def_level_i`=2; drop `enable_i` mid-window at count 3 → next cycle IDLE, `err_count_o`=0, level 2. Change `def_level_i` to 7 with NumLevels=4 → `set_level_o`=3.
6. `rst_i` asserted mid-SETTLE → next cycle all outputs 0, state IDLE.
